mux_sel_sequencer: RTL and testbench



---
 rtl/mux_sel_sequencer.sv | 64 ++++++
 tb/tb_mux_sel_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: parallel-to-serial driver that latches a word and steps an 8:1 mux select with hold/backpressure.
// Define MUXSEQ_MSB_FIRST_EN for MSB-first order (sel 7..0); default is LSB-first (sel 0..7).
module mux_sel_sequencer #(
    parameter int HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] din,
    output logic [2:0] sel,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       last,
    output logic       busy
);
`ifdef MUXSEQ_MSB_FIRST_EN
    localparam logic [2:0] START_SEL = 3'd7;
    localparam logic [2:0] LAST_SEL  = 3'd0;
    localparam logic       STEP_DN   = 1'b1;
`else
    localparam logic [2:0] START_SEL = 3'd0;
    localparam logic [2:0] LAST_SEL  = 3'd7;
    localparam logic       STEP_DN   = 1'b0;
`endif
    localparam logic [3:0] RELOAD = 4'(HOLD - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;
    logic       load;

    assign busy      = state == SHIFT;
    assign bit_valid = busy && cnt == 4'd0;
    assign last      = busy && sel == LAST_SEL;
    assign accept    = bit_valid && bit_ready;
    // a word may load in IDLE or on the final accept, giving back-to-back words with no bubble
    assign in_ready  = !rst && (!busy || (accept && last));
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            din   <= 8'h00;
            sel   <= START_SEL;
            cnt   <= 4'd0;
        end else if (load) begin
            state <= SHIFT;
            din   <= in_data;
            sel   <= START_SEL;
            cnt   <= RELOAD;
        end else if (accept && last) begin
            state <= IDLE;
        end else if (accept) begin
            sel <= STEP_DN ? sel - 3'd1 : sel + 3'd1;
            cnt <= RELOAD;
        end else if (busy && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: directed self-checking bench; HOLD=1 and HOLD=3 instances share clk and rst.
module tb_mux_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, bit_valid, bit_ready, last, busy;
    logic [7:0] in_data, din;
    logic [2:0] sel;
    logic       in_valid3, in_ready3, bit_valid3, bit_ready3, last3, busy3;
    logic [7:0] in_data3, din3;
    logic [2:0] sel3;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mux_sel_sequencer #(.HOLD(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .din(din), .sel(sel), .bit_valid(bit_valid), .bit_ready(bit_ready), .last(last), .busy(busy)
    );

    mux_sel_sequencer #(.HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .din(din3), .sel(sel3), .bit_valid(bit_valid3), .bit_ready(bit_ready3), .last(last3), .busy(busy3)
    );

    function automatic logic [2:0] pos(input int k);
`ifdef MUXSEQ_MSB_FIRST_EN
        return 3'(7 - k);
`else
        return 3'(k);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        bit_ready = 1'b1;
        in_valid3 = 1'b0;
        in_data3 = 8'h00;
        bit_ready3 = 1'b1;
        #1;
        n_checks++;
        if (din !== 8'h00 || sel !== pos(0) || bit_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: din=%h sel=%0d bv=%b last=%b busy=%b in_ready=%b, required 00 %0d 0 0 0 0",
                     din, sel, bit_valid, last, busy, in_ready, pos(0));
        end
        tick;
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_serial_word;
        logic [7:0] w = 8'b10111010;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data = w;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (sel !== pos(k) || bit_valid !== 1'b1 || last !== (k == 7) || busy !== 1'b1 ||
                in_ready !== (k == 7) || din[sel] !== w[pos(k)]) begin
                n_fail++;
                $display("FAIL serial k=%0d: sel=%0d bv=%b last=%b busy=%b rdy=%b y=%b, required %0d 1 %b 1 %b %b",
                         k, sel, bit_valid, last, busy, in_ready, din[sel], pos(k), k == 7, k == 7, w[pos(k)]);
            end
            tick;
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || sel !== pos(7) || din !== w || bit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL serial_end: busy=%b rdy=%b sel=%0d din=%h bv=%b, required 0 1 %0d %h 0",
                     busy, in_ready, sel, din, bit_valid, pos(7), w);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w1 = 8'hA5;
        logic [7:0] w2 = 8'h3C;
        logic [7:0] wk;
        in_valid = 1'b1;
        in_data = w1;
        tick;
        in_data = w2;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) in_valid = 1'b0;
            wk = (k < 8) ? w1 : w2;
            n_checks++;
            if (bit_valid !== 1'b1 || sel !== pos(k % 8) || din[sel] !== wk[pos(k % 8)] || in_ready !== (k == 7 || k == 15)) begin
                n_fail++;
                $display("FAIL b2b k=%0d: bv=%b sel=%0d y=%b rdy=%b, required 1 %0d %b %b",
                         k, bit_valid, sel, din[sel], in_ready, pos(k % 8), wk[pos(k % 8)], k == 7 || k == 15);
            end
            tick;
        end
        n_checks++;
        if (busy !== 1'b0 || din !== w2) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%b din=%h, required 0 %h", busy, din, w2);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] w = 8'b10111010;
        in_valid = 1'b1;
        in_data = w;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                bit_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    n_checks++;
                    if (sel !== pos(3) || bit_valid !== 1'b1 || in_ready !== 1'b0 || din !== w) begin
                        n_fail++;
                        $display("FAIL stall s=%0d: sel=%0d bv=%b rdy=%b din=%h, required %0d 1 0 %h",
                                 s, sel, bit_valid, in_ready, din, pos(3), w);
                    end
                    tick;
                end
                bit_ready = 1'b1;
            end
            n_checks++;
            if (sel !== pos(k) || bit_valid !== 1'b1 || din[sel] !== w[pos(k)] || last !== (k == 7)) begin
                n_fail++;
                $display("FAIL bp k=%0d: sel=%0d bv=%b y=%b last=%b, required %0d 1 %b %b",
                         k, sel, bit_valid, din[sel], last, pos(k), w[pos(k)], k == 7);
            end
            tick;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_hold3;
        logic [7:0] w = 8'hC6;
        in_valid3 = 1'b1;
        in_data3 = w;
        tick;
        in_valid3 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            n_checks++;
            if (sel3 !== pos(c / 3) || bit_valid3 !== (c % 3 == 2) || last3 !== (c / 3 == 7) || busy3 !== 1'b1 ||
                din3[sel3] !== w[pos(c / 3)]) begin
                n_fail++;
                $display("FAIL hold3 c=%0d: sel=%0d bv=%b last=%b busy=%b y=%b, required %0d %b %b 1 %b",
                         c, sel3, bit_valid3, last3, busy3, din3[sel3], pos(c / 3), c % 3 == 2, c / 3 == 7, w[pos(c / 3)]);
            end
            tick;
        end
        n_checks++;
        if (busy3 !== 1'b0 || in_ready3 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold3_end: busy=%b rdy=%b, required 0 1", busy3, in_ready3);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w = 8'b10111010;
        in_valid = 1'b1;
        in_data = w;
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        n_checks++;
        if (sel !== pos(5) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pos: sel=%0d busy=%b, required %0d 1", sel, busy, pos(5));
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (din !== 8'h00 || sel !== pos(0) || bit_valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: din=%h sel=%0d bv=%b last=%b busy=%b rdy=%b, required 00 %0d 0 0 0 0",
                     din, sel, bit_valid, last, busy, in_ready, pos(0));
        end
        tick;
        rst = 1'b0;
        tick;
        n_checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: bv=%b busy=%b rdy=%b, required 0 0 1", bit_valid, busy, in_ready);
        end
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (sel !== pos(k) || bit_valid !== 1'b1 || din[sel] !== 1'b1) begin
                n_fail++;
                $display("FAIL ff k=%0d: sel=%0d bv=%b y=%b, required %0d 1 1", k, sel, bit_valid, din[sel], pos(k));
            end
            tick;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ff_end: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_serial_word;
        test_back_to_back;
        test_backpressure;
        test_hold3;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
